mem_seq_ctrl: RTL and testbench

Sequencer for the load/store memory path of the 16-bit datapath.
- Accepts one load or store command at a time.
- Drives the address-mux select: direct address, or register-based address from the ALU result.
- Runs a req/ack handshake with data memory.
- Returns load data with a one-cycle write-enable pulse.
- Sits between the decode/control unit, the ALU and the data-memory interface.

---
 rtl/mem_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: load/store sequencer for the 16-bit datapath memory path.
//
// Accepts one load or store command at a time. It resolves the address
// (direct, or the ALU result when reg_addr is set), runs a req/ack handshake
// with data memory, and returns load data together with a one-cycle rd_we
// pulse.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a request that goes
// TIMEOUT REQ cycles without mem_ack. An abort ends with done=1 and err=1.
// When the macro is not defined, REQ waits indefinitely and o_err is tied 0.
//
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   i_start             command strobe, sampled only in IDLE
//   i_is_load/store     command type; exactly one must be set
//   i_reg_addr          1 = use i_alu_result as address, 0 = use i_addr
//   i_addr              direct address
//   i_store_data        store write data
//   i_alu_valid         i_alu_result valid this cycle
//   i_alu_result        computed address
//   o_addr_sel          address-mux select (1 = ALU result)
//   o_mem_req/o_mem_we  memory request / write enable
//   o_mem_addr          registered memory address
//   o_mem_wdata         registered write data
//   i_mem_ack           memory acknowledge / read data valid
//   i_mem_rdata         memory read data
//   o_rd_data           captured load data
//   o_rd_we             one-cycle load-result write pulse
//   o_busy              command in flight
//   o_done              one-cycle completion pulse
//   o_err               one-cycle abort (timeout) pulse
module mem_seq_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic              i_reg_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_result,
  output logic              o_addr_sel,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAlu  = 2'd1;
  localparam logic [1:0] StReq  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_d;
  logic              r_is_load;
  logic              r_reg_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rd_data;

  logic w_cmd_ok;
  logic w_to_hit;     // request aborted by timeout this cycle
  logic w_timed_out;  // current DONE is an abort

  // Both or neither of load/store set is not a valid command.
  assign w_cmd_ok = i_start & (i_is_load ^ i_is_store);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_tmo_cnt;
  logic            r_timed_out;

  // Count holds the number of un-acked REQ cycles already elapsed, so the
  // abort fires on the TIMEOUT-th cycle. An ack in that cycle wins.
  assign w_to_hit    = (r_state == StReq) & ~i_mem_ack &
                       (r_tmo_cnt == CntW'(TIMEOUT - 1));
  assign w_timed_out = r_timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else begin
      if (r_state != StReq && w_state_d == StReq) begin
        r_tmo_cnt <= '0;
      end else if (r_state == StReq && !i_mem_ack) begin
        r_tmo_cnt <= r_tmo_cnt + CntW'(1);
      end

      if (r_state == StReq) begin
        r_timed_out <= w_to_hit;
      end else if (r_state == StIdle) begin
        r_timed_out <= 1'b0;
      end
    end
  end
`else
  assign w_to_hit    = 1'b0;
  assign w_timed_out = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (w_cmd_ok) w_state_d = i_reg_addr ? StAlu : StReq;
      StAlu:  if (i_alu_valid) w_state_d = StReq;
      StReq:  if (i_mem_ack || w_to_hit) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_is_load   <= 1'b0;
      r_reg_addr  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
    end else begin
      r_state <= w_state_d;

      if (r_state == StIdle && w_cmd_ok) begin
        r_is_load   <= i_is_load;
        r_reg_addr  <= i_reg_addr;
        r_mem_wdata <= i_store_data;
        if (!i_reg_addr) begin
          r_mem_addr <= i_addr;
        end
      end

      if (r_state == StAlu && i_alu_valid) begin
        r_mem_addr <= i_alu_result;
      end

      if (r_state == StReq && i_mem_ack && r_is_load) begin
        r_rd_data <= i_mem_rdata;
      end
    end
  end

  assign o_busy      = (r_state != StIdle);
  assign o_addr_sel  = o_busy & r_reg_addr;
  assign o_mem_req   = (r_state == StReq);
  assign o_mem_we    = (r_state == StReq) & ~r_is_load;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_rd_data   = r_rd_data;
  assign o_done      = (r_state == StDone);
  assign o_rd_we     = (r_state == StDone) & r_is_load & ~w_timed_out;
  assign o_err       = (r_state == StDone) & w_timed_out;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: directed self-checking bench for mem_seq_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Timeout scenarios run only when MEM_TIMEOUT_EN is defined.
module tb_mem_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_is_load;
  logic        i_is_store;
  logic        i_reg_addr;
  logic [15:0] i_addr;
  logic [15:0] i_store_data;
  logic        i_alu_valid;
  logic [15:0] i_alu_result;
  logic        o_addr_sel;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic [15:0] o_rd_data;
  logic        o_rd_we;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_rdwe   = 0;
  int n_err    = 0;

  mem_seq_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_is_load   (i_is_load),
    .i_is_store  (i_is_store),
    .i_reg_addr  (i_reg_addr),
    .i_addr      (i_addr),
    .i_store_data(i_store_data),
    .i_alu_valid (i_alu_valid),
    .i_alu_result(i_alu_result),
    .o_addr_sel  (o_addr_sel),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_rd_data   (o_rd_data),
    .o_rd_we     (o_rd_we),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_done <= n_done + int'(o_done);
      n_rdwe <= n_rdwe + int'(o_rd_we);
      n_err  <= n_err + int'(o_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_is_load    = 1'b0;
    i_is_store   = 1'b0;
    i_reg_addr   = 1'b0;
    i_addr       = '0;
    i_store_data = '0;
    i_alu_valid  = 1'b0;
    i_alu_result = '0;
    i_mem_ack    = 1'b0;
    i_mem_rdata  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_mem_req", o_mem_req, 0);
    check("rst_mem_addr", o_mem_addr, 0);
    check("rst_mem_wdata", o_mem_wdata, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_done_err_rdwe", {o_done, o_err, o_rd_we, o_addr_sel, o_mem_we}, 0);
    rst_n = 1'b1;
    cyc();

    // Direct load, zero-wait memory: start c0, req c1, done c2
    i_start = 1; i_is_load = 1; i_addr = 16'h1234; i_reg_addr = 0; i_store_data = 16'h9999;
    smp();
    check("t1_c0_busy", o_busy, 0);
    cyc();
    i_start = 0; i_is_load = 0; i_mem_ack = 1; i_mem_rdata = 16'hBEEF;
    smp();
    check("t1_c1_req", o_mem_req, 1);
    check("t1_c1_we", o_mem_we, 0);
    check("t1_c1_addr", o_mem_addr, 16'h1234);
    check("t1_c1_sel_busy", {o_addr_sel, o_busy, o_done}, 3'b010);
    cyc();
    i_mem_ack = 0;
    smp();
    check("t1_c2_done", o_done, 1);
    check("t1_c2_rd_we", o_rd_we, 1);
    check("t1_c2_rd_data", o_rd_data, 16'hBEEF);
    check("t1_c2_req_err", {o_mem_req, o_err}, 0);
    cyc();
    smp();
    check("t1_c3_idle", {o_busy, o_done, o_rd_we}, 0);
    check("t1_cnt_done", n_done, 1);

    // Register-addressed store: ALU valid on 3rd ALU cycle, ack on 2nd REQ cycle
    cyc();
    i_start = 1; i_is_store = 1; i_reg_addr = 1; i_store_data = 16'h5A5A; i_addr = 16'hFFFF;
    cyc();
    i_start = 0; i_is_store = 0; i_reg_addr = 0;
    for (int k = 1; k <= 3; k++) begin
      i_alu_valid  = (k == 3);
      i_alu_result = (k == 3) ? 16'h00F0 : 16'h0BAD;
      smp();
      check($sformatf("t2_alu%0d_sel", k), {o_addr_sel, o_busy, o_mem_req}, 3'b110);
      cyc();
    end
    i_alu_valid = 0;
    smp();
    check("t2_req1_req_we", {o_mem_req, o_mem_we, o_addr_sel}, 3'b111);
    check("t2_req1_addr", o_mem_addr, 16'h00F0);
    check("t2_req1_wdata", o_mem_wdata, 16'h5A5A);
    cyc();
    i_mem_ack = 1; i_mem_rdata = 16'h1357;
    smp();
    check("t2_req2_req", {o_mem_req, o_addr_sel}, 2'b11);
    cyc();
    i_mem_ack = 0;
    smp();
    check("t2_done", {o_done, o_rd_we, o_err, o_mem_req, o_addr_sel}, 5'b10001);
    check("t2_rd_data_kept", o_rd_data, 16'hBEEF);
    cyc();
    smp();
    check("t2_idle", {o_busy, o_addr_sel}, 0);
    check("t2_cnt_done", n_done, 2);
    check("t2_cnt_rdwe", n_rdwe, 1);

    // Protocol ignores: invalid commands
    cyc();
    i_start = 1; i_is_load = 1; i_is_store = 1;
    cyc();
    smp();
    check("t3_both_busy", o_busy, 0);
    i_is_load = 0; i_is_store = 0;
    cyc();
    smp();
    check("t3_neither_busy", o_busy, 0);

    // Load at 0x0042 with a second command held during REQ and DONE
    i_is_load = 1; i_addr = 16'h0042;
    cyc();
    i_is_load = 0; i_is_store = 1; i_addr = 16'h0999;
    smp();
    check("t3_req1_addr", o_mem_addr, 16'h0042);
    check("t3_req1_we", {o_mem_req, o_mem_we}, 2'b10);
    cyc();
    i_mem_ack = 1; i_mem_rdata = 16'h1111;
    smp();
    check("t3_req2_we", {o_mem_req, o_mem_we}, 2'b10);
    cyc();
    i_mem_ack = 0;
    smp();
    check("t3_done", {o_done, o_rd_we}, 2'b11);
    cyc();
    i_start = 0; i_is_store = 0;
    smp();
    check("t3_after_done_idle", {o_busy, o_mem_req}, 0);
    cyc();
    smp();
    check("t3_still_idle", o_busy, 0);
    check("t3_rd_data", o_rd_data, 16'h1111);
    check("t3_cnt_done", n_done, 3);

    // Spurious ack in IDLE
    i_mem_ack = 1; i_mem_rdata = 16'hDEAD;
    cyc();
    cyc();
    smp();
    check("t3_spur_idle", {o_busy, o_done}, 0);
    i_mem_ack = 0;
    cyc();
    check("t3_spur_cnt_done", n_done, 3);
    check("t3_spur_rd_data", o_rd_data, 16'h1111);

    // Reset asserted mid-REQ
    i_start = 1; i_is_store = 1; i_addr = 16'h0AAA; i_store_data = 16'h7777;
    cyc();
    i_start = 0; i_is_store = 0;
    smp();
    check("t4_req", {o_mem_req, o_mem_we}, 2'b11);
    check("t4_wdata", o_mem_wdata, 16'h7777);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_ctrl", {o_mem_req, o_mem_we, o_busy, o_done}, 0);
    check("t4_rst_addr", o_mem_addr, 0);
    check("t4_rst_wdata", o_mem_wdata, 0);
    check("t4_rst_rd_data", o_rd_data, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t4_cnt_done", n_done, 3);

    // Fresh load after reset
    i_start = 1; i_is_load = 1; i_addr = 16'h0055;
    cyc();
    i_start = 0; i_is_load = 0; i_mem_ack = 1; i_mem_rdata = 16'hBEEF;
    smp();
    check("t4_load_addr", o_mem_addr, 16'h0055);
    cyc();
    i_mem_ack = 0;
    smp();
    check("t4_load_done", {o_done, o_rd_we, o_err}, 3'b110);
    check("t4_load_rd_data", o_rd_data, 16'hBEEF);
    cyc();

`ifdef MEM_TIMEOUT_EN
    // No ack: 15 REQ cycles, then abort
    i_start = 1; i_is_load = 1; i_addr = 16'h0100;
    cyc();
    i_start = 0; i_is_load = 0;
    for (int k = 1; k <= 15; k++) begin
      smp();
      check($sformatf("t5_req%0d", k), o_mem_req, 1);
      cyc();
    end
    smp();
    check("t5_abort", {o_mem_req, o_done, o_err, o_rd_we}, 4'b0110);
    check("t5_rd_data", o_rd_data, 16'hBEEF);
    cyc();
    smp();
    check("t5_idle", {o_busy, o_err}, 0);

    // Ack on the 15th REQ cycle wins
    i_start = 1; i_is_load = 1; i_addr = 16'h0200;
    cyc();
    i_start = 0; i_is_load = 0;
    repeat (14) cyc();
    i_mem_ack = 1; i_mem_rdata = 16'hCAFE;
    smp();
    check("t6_req15", o_mem_req, 1);
    cyc();
    i_mem_ack = 0;
    smp();
    check("t6_done", {o_done, o_err, o_rd_we}, 3'b101);
    check("t6_rd_data", o_rd_data, 16'hCAFE);
    cyc();
    check("t6_cnt_err", n_err, 1);
`else
    check("no_timeout_cnt_err", n_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
